bus_dest_regs: RTL

- Destination side of the 8-source CPU bus: a bank of 8 registers that capture the bus value on command.
- Each command names one register and applies LD (bus value), INR (increment) or CLR (clear) to it.
- The register outputs reg0..reg7 feed back into the bus source mux as in0..in7.
- Commands pass through one registered stage, so the controller can issue one command per cycle with a freeze (hold) input.

---
 rtl/bus_dest_regs_pkg.sv | 27 ++
 rtl/bus_dest_stage.sv | 36 +++
 rtl/bus_dest_regs.sv | 108 ++++++++++
 3 files changed

// File: rtl/bus_dest_regs_pkg.sv
// Shared types and constants for the bus destination register bank.
// Command struct data field is sized for the default bus width.
package bus_dest_regs_pkg;

  localparam int DST_W  = 3;
  localparam int NREGS  = 8;
  localparam int OP_W   = 2;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_NOP = 2'b00;
  localparam logic [OP_W-1:0] OP_LD  = 2'b01;
  localparam logic [OP_W-1:0] OP_INR = 2'b10;
  localparam logic [OP_W-1:0] OP_CLR = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic is_write(
    input logic [OP_W-1:0] op
  );
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/bus_dest_stage.sv
// Command pipeline register with hold/ready handshake.
// Only LD keeps the bus value; other ops store zero data.
module bus_dest_stage
  import bus_dest_regs_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             cmd_valid,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [DST_W-1:0] cmd_dst,
  input  logic [WIDTH-1:0] bus_in,
  output logic             cmd_ready,
  output logic             stage_valid,
  output cmd_t             stage_cmd
);

  assign cmd_ready = ~hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_cmd   <= '0;
    end else if (!hold) begin
      stage_valid   <= cmd_valid & is_write(cmd_op);
      stage_cmd.op  <= cmd_op;
      stage_cmd.dst <= cmd_dst;
      stage_cmd.data <= (cmd_op == OP_LD)
                        ? DATA_W'(bus_in)
                        : '0;
    end
  end

endmodule

// File: rtl/bus_dest_regs.sv
// Eight bus destination registers with LD/INR/CLR commands.
// Optional BUS_DEST_WRCNT_EN adds a 16-bit applied-op counter.
module bus_dest_regs
  import bus_dest_regs_pkg::*;
#(
  parameter int              WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             cmd_valid,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [DST_W-1:0] cmd_dst,
  output logic             cmd_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7,
`ifdef BUS_DEST_WRCNT_EN
  output logic [15:0]      wr_cnt,
`endif
  output logic             ovf,
  output logic             zero
);

  logic             stage_valid;
  cmd_t             stage_cmd;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             wrap;
  logic             apply;

  bus_dest_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .bus_in     (bus_in),
    .cmd_ready  (cmd_ready),
    .stage_valid(stage_valid),
    .stage_cmd  (stage_cmd)
  );

  assign apply = stage_valid & ~hold;

  // INR/CLR read the register now, so back-to-back ops need no bypass
  always_comb begin
    cur  = regs[stage_cmd.dst];
    res  = cur;
    wrap = 1'b0;
    unique case (stage_cmd.op)
      OP_LD:  res = WIDTH'(stage_cmd.data);
      OP_INR: begin
        res  = cur + 1'b1;
        wrap = &cur;
      end
      OP_CLR: res = '0;
      default: res = cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= RST_VAL;
      end
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      ovf <= apply & wrap;
      if (apply) begin
        regs[stage_cmd.dst] <= res;
        zero                <= (res == '0);
      end
    end
  end

`ifdef BUS_DEST_WRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (apply) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif

  assign reg0 = regs[0];
  assign reg1 = regs[1];
  assign reg2 = regs[2];
  assign reg3 = regs[3];
  assign reg4 = regs[4];
  assign reg5 = regs[5];
  assign reg6 = regs[6];
  assign reg7 = regs[7];

endmodule
